// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 2-bit ALU core and its round-robin front end:
// operand width, opcode encodings, arbiter FSM states, performance counter
// width and a saturating increment helper.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W      = 2;
    localparam int PERF_CNT_W = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational 2-bit ALU.
//   a, b      : operands
//   sel       : opcode (ADD, SUB, AND, OR; 1xx is invalid)
//   y         : result
//   zero      : y == 0
//   carry     : ADD carry-out, SUB borrow (a < b unsigned); 0 for logic ops
//   overflow  : signed overflow for ADD/SUB; 0 for logic ops
//   error     : invalid opcode (y = 0, carry/overflow = 0)
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [2:0]       sel,
    output logic [ALU_W-1:0] y,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             error
);

    logic [ALU_W:0] ext;

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        ext      = '0;
        y        = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        error    = 1'b0;
        case (sel)
            OP_ADD: begin
                ext      = {1'b0, a} + {1'b0, b};
                y        = ext[ALU_W-1:0];
                carry    = ext[ALU_W];
                overflow = (a[ALU_W-1] == b[ALU_W-1]) && (y[ALU_W-1] != a[ALU_W-1]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow.
                ext      = {1'b0, a} - {1'b0, b};
                y        = ext[ALU_W-1:0];
                carry    = ext[ALU_W];
                overflow = (a[ALU_W-1] != b[ALU_W-1]) && (y[ALU_W-1] != a[ALU_W-1]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: error = 1'b1;
        endcase
        zero = (y == '0);
    end

endmodule

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: finds the first asserted request at or
// above ptr, wrapping modulo N.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   grant     : one-hot grant (all zero when nothing requests)
//   winner    : binary index of the granted request
//   any_valid : at least one request asserted
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] winner,
    output logic             any_valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N);
            if (!any_valid && req[idx]) begin
                any_valid  = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_rr_arbiter
// Shares one alu_core among NUM_REQ requesters. IDLE arbitrates round-robin and
// captures the winning op, EXEC runs the ALU from the captured operands and
// registers its outputs, RESP presents them until the consumer accepts.
// One op outstanding at a time.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready     : per-requester handshake (ready only in IDLE)
//   req_a/req_b/req_sel     : packed per-requester operands and opcode
//   rsp_valid/rsp_ready     : response handshake
//   rsp_id, rsp_out, rsp_*  : owner id, result and flags of the response
//   busy                    : FSM not in IDLE
// Optional (define ALU_PERF_CNT_EN):
//   perf_grant_cnt          : per-requester saturating grant counters
//   perf_err_cnt            : saturating count of accepted error responses
// -----------------------------------------------------------------------------
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int DATA_W  = ALU_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]     req_a,
    input  logic [NUM_REQ*DATA_W-1:0]     req_b,
    input  logic [NUM_REQ*3-1:0]          req_sel,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_W-1:0]             rsp_out,
    output logic                          rsp_zero,
    output logic                          rsp_carry,
    output logic                          rsp_overflow,
    output logic                          rsp_error,
`ifdef ALU_PERF_CNT_EN
    output logic [NUM_REQ*PERF_CNT_W-1:0] perf_grant_cnt,
    output logic [PERF_CNT_W-1:0]         perf_err_cnt,
`endif
    output logic                          busy
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [2:0]          op_sel_q, op_sel_d;
    logic [ID_W-1:0]     op_id_q, op_id_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_out_q, rsp_out_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic                rsp_carry_q, rsp_carry_d;
    logic                rsp_overflow_q, rsp_overflow_d;
    logic                rsp_error_q, rsp_error_d;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     winner;
    logic                any_valid;
    logic                req_hs, rsp_hs;

    logic [DATA_W-1:0]   alu_y;
    logic                alu_zero, alu_carry, alu_overflow, alu_error;

    rr_pick #(.N(NUM_REQ), .IDX_W(ID_W)) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Operands come only from the op registers, so the ALU inputs never follow
    // the request ports.
    alu_core u_alu (
        .a        (op_a_q),
        .b        (op_b_q),
        .sel      (op_sel_q),
        .y        (alu_y),
        .zero     (alu_zero),
        .carry    (alu_carry),
        .overflow (alu_overflow),
        .error    (alu_error)
    );

    assign req_ready = (state_q == ST_IDLE) ? grant : '0;
    assign req_hs    = (state_q == ST_IDLE) && any_valid;
    assign rsp_hs    = (state_q == ST_RESP) && rsp_ready;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        op_sel_d       = op_sel_q;
        op_id_d        = op_id_q;
        rsp_id_d       = rsp_id_q;
        rsp_out_d      = rsp_out_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_error_d    = rsp_error_q;
        case (state_q)
            ST_IDLE: begin
                if (req_hs) begin
                    op_a_d   = req_a[winner*DATA_W +: DATA_W];
                    op_b_d   = req_b[winner*DATA_W +: DATA_W];
                    op_sel_d = req_sel[winner*3 +: 3];
                    op_id_d  = winner;
                    rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_id_d       = op_id_q;
                rsp_out_d      = alu_y;
                rsp_zero_d     = alu_zero;
                rsp_carry_d    = alu_carry;
                rsp_overflow_d = alu_overflow;
                rsp_error_d    = alu_error;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            op_sel_q       <= '0;
            op_id_q        <= '0;
            rsp_id_q       <= '0;
            rsp_out_q      <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            rsp_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            op_sel_q       <= op_sel_d;
            op_id_q        <= op_id_d;
            rsp_id_q       <= rsp_id_d;
            rsp_out_q      <= rsp_out_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_error_q    <= rsp_error_d;
        end
    end

    assign rsp_valid    = (state_q == ST_RESP);
    assign busy         = (state_q != ST_IDLE);
    assign rsp_id       = rsp_id_q;
    assign rsp_out      = rsp_out_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_error    = rsp_error_q;

`ifdef ALU_PERF_CNT_EN
    logic [NUM_REQ*PERF_CNT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [PERF_CNT_W-1:0]         err_cnt_q, err_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        err_cnt_d   = err_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_hs && grant[i]) begin
                grant_cnt_d[i*PERF_CNT_W +: PERF_CNT_W] =
                    sat_inc(grant_cnt_q[i*PERF_CNT_W +: PERF_CNT_W]);
            end
        end
        if (rsp_hs && rsp_error_q) err_cnt_d = sat_inc(err_cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign perf_grant_cnt = grant_cnt_q;
    assign perf_err_cnt   = err_cnt_q;
`else
    // Response handshake only feeds the performance counters.
    logic unused_rsp_hs;
    assign unused_rsp_hs = rsp_hs;
`endif

endmodule
